branch_hazard_ctrl: RTL

- Sequences ID-stage branch/jr resolution for the 5-stage MIPS pipeline.
- Detects when a branch operand in ID is not yet forwardable from MEM/WB and stalls the front end for the required number of cycles.
- Drives the branch forwarding mux selects (RF / ALUOut_MEM / RegWriteData_WB).
- Flushes IF/ID on a resolved taken branch.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/branch_hazard_ctrl_if.sv | 49 ++++
 rtl/branch_hazard_ctrl_operand_check.sv | 46 ++++
 rtl/branch_hazard_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for ID-stage branch hazard control: forward-select
// encodings, stall-length constants and the hazard FSM state type.
package cpu_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  localparam int STALL_LOAD_EX  = 2;
  localparam int STALL_ALU_EX   = 1;
  localparam int STALL_LOAD_MEM = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hz_state_t;

  // A MEM-stage load cannot forward its ALUOut (it is only an address), so
  // it falls through to the WB check.
  function automatic logic [1:0] fwd_pick(input logic mem_alu_hit, input logic wb_hit);
    if (mem_alu_hit) return FWD_MEM;
    if (wb_hit)      return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// Bundle of ID-stage branch inputs, producer information from EX/MEM/WB and
// the front-end control outputs of branch_hazard_ctrl.
interface branch_hazard_ctrl_if #(
  parameter int STAT_W = 32
);
  logic              Branch_ID;
  logic              UseRt_ID;
  logic              JumpReg_ID;
  logic [4:0]        rs_ID;
  logic [4:0]        rt_ID;
  logic              BranchTaken_ID;
  logic              RegWrite_EX;
  logic              MemRead_EX;
  logic [4:0]        RegWriteAddr_EX;
  logic              RegWrite_MEM;
  logic              MemRead_MEM;
  logic [4:0]        RegWriteAddr_MEM;
  logic              RegWrite_WB;
  logic [4:0]        RegWriteAddr_WB;

  logic              PCWrite;
  logic              IFIDWrite;
  logic              IDEXBubble;
  logic              IFIDFlush;
  logic [1:0]        FwdSelA;
  logic [1:0]        FwdSelB;
  logic              Stalling;
  logic [STAT_W-1:0] BranchCount;
  logic [STAT_W-1:0] TakenCount;
  logic [STAT_W-1:0] StallCycles;

  modport master (
    output Branch_ID, UseRt_ID, JumpReg_ID, rs_ID, rt_ID, BranchTaken_ID,
           RegWrite_EX, MemRead_EX, RegWriteAddr_EX,
           RegWrite_MEM, MemRead_MEM, RegWriteAddr_MEM,
           RegWrite_WB, RegWriteAddr_WB,
    input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, FwdSelA, FwdSelB,
           Stalling, BranchCount, TakenCount, StallCycles
  );

  modport slave (
    input  Branch_ID, UseRt_ID, JumpReg_ID, rs_ID, rt_ID, BranchTaken_ID,
           RegWrite_EX, MemRead_EX, RegWriteAddr_EX,
           RegWrite_MEM, MemRead_MEM, RegWriteAddr_MEM,
           RegWrite_WB, RegWriteAddr_WB,
    output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, FwdSelA, FwdSelB,
           Stalling, BranchCount, TakenCount, StallCycles
  );
endinterface

// File: rtl/branch_hazard_ctrl_operand_check.sv
// Per-operand hazard check for an ID-stage branch source register: required
// stall length and forwarding mux select.
module branch_operand_check
  import cpu_pkg::*;
#(
  parameter int STALL_CNT_W = 2
) (
  input  logic                   active,
  input  logic [4:0]             src,
  input  logic                   RegWrite_EX,
  input  logic                   MemRead_EX,
  input  logic [4:0]             RegWriteAddr_EX,
  input  logic                   RegWrite_MEM,
  input  logic                   MemRead_MEM,
  input  logic [4:0]             RegWriteAddr_MEM,
  input  logic                   RegWrite_WB,
  input  logic [4:0]             RegWriteAddr_WB,
  output logic [STALL_CNT_W-1:0] stall_req,
  output logic [1:0]             fwd_sel
);

  logic nonzero;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign nonzero = (src != 5'd0);
  assign ex_hit  = nonzero && RegWrite_EX  && (RegWriteAddr_EX  == src);
  assign mem_hit = nonzero && RegWrite_MEM && (RegWriteAddr_MEM == src);
  assign wb_hit  = nonzero && RegWrite_WB  && (RegWriteAddr_WB  == src);

  always_comb begin
    stall_req = '0;
    if (active) begin
      if (ex_hit && MemRead_EX)
        stall_req = STALL_CNT_W'(STALL_LOAD_EX);
      else if (ex_hit)
        stall_req = STALL_CNT_W'(STALL_ALU_EX);
      else if (mem_hit && MemRead_MEM)
        stall_req = STALL_CNT_W'(STALL_LOAD_MEM);
    end
  end

  assign fwd_sel = fwd_pick(mem_hit && !MemRead_MEM, wb_hit);

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch/jr hazard sequencer: stalls the front end until branch
// operands are forwardable, drives forward selects, flushes IF/ID on taken
// branches. Optional statistics counters under BRANCH_HAZARD_STATS_EN.
module branch_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int STALL_CNT_W = 2,
  parameter int STAT_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  branch_hazard_ctrl_if.slave hz
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

  logic                   rs_active;
  logic                   rt_active;
  logic [STALL_CNT_W-1:0] rs_req;
  logic [STALL_CNT_W-1:0] rt_req;
  logic [STALL_CNT_W-1:0] need_n;
  logic [1:0]             rs_fwd;
  logic [1:0]             rt_fwd;
  hz_state_t              state_q;
  hz_state_t              state_d;
  logic [STALL_CNT_W-1:0] cnt_q;
  logic [STALL_CNT_W-1:0] cnt_d;
  logic                   stall;
  logic                   flush;

  assign rs_active = hz.Branch_ID | hz.JumpReg_ID;
  assign rt_active = hz.Branch_ID & hz.UseRt_ID;
  assign need_n    = (rs_req > rt_req) ? rs_req : rt_req;

  branch_operand_check #(.STALL_CNT_W(STALL_CNT_W)) u_rs_check (
    .active           (rs_active),
    .src              (hz.rs_ID),
    .RegWrite_EX      (hz.RegWrite_EX),
    .MemRead_EX       (hz.MemRead_EX),
    .RegWriteAddr_EX  (hz.RegWriteAddr_EX),
    .RegWrite_MEM     (hz.RegWrite_MEM),
    .MemRead_MEM      (hz.MemRead_MEM),
    .RegWriteAddr_MEM (hz.RegWriteAddr_MEM),
    .RegWrite_WB      (hz.RegWrite_WB),
    .RegWriteAddr_WB  (hz.RegWriteAddr_WB),
    .stall_req        (rs_req),
    .fwd_sel          (rs_fwd)
  );

  branch_operand_check #(.STALL_CNT_W(STALL_CNT_W)) u_rt_check (
    .active           (rt_active),
    .src              (hz.rt_ID),
    .RegWrite_EX      (hz.RegWrite_EX),
    .MemRead_EX       (hz.MemRead_EX),
    .RegWriteAddr_EX  (hz.RegWriteAddr_EX),
    .RegWrite_MEM     (hz.RegWrite_MEM),
    .MemRead_MEM      (hz.MemRead_MEM),
    .RegWriteAddr_MEM (hz.RegWriteAddr_MEM),
    .RegWrite_WB      (hz.RegWrite_WB),
    .RegWriteAddr_WB  (hz.RegWriteAddr_WB),
    .stall_req        (rt_req),
    .fwd_sel          (rt_fwd)
  );

  // The first stall cycle is issued from IDLE (Mealy); cnt then holds the
  // number of additional STALL cycles still owed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (need_n != '0) begin
          stall = 1'b1;
          cnt_d = need_n - CNT_ONE;
          if (need_n > CNT_ONE)
            state_d = STALL;
        end
      end
      STALL: begin
        stall = 1'b1;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE || !rs_active) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (reset)
      stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign flush = !reset && !stall &&
                 ((hz.Branch_ID && hz.BranchTaken_ID) || hz.JumpReg_ID);

  always_comb begin
    hz.PCWrite    = 1'b1;
    hz.IFIDWrite  = 1'b1;
    hz.IDEXBubble = 1'b0;
    hz.Stalling   = 1'b0;
    hz.IFIDFlush  = flush;
    hz.FwdSelA    = FWD_RF;
    hz.FwdSelB    = FWD_RF;
    if (!reset) begin
      hz.PCWrite    = !stall;
      hz.IFIDWrite  = !stall;
      hz.IDEXBubble = stall;
      hz.Stalling   = stall;
      hz.FwdSelA    = rs_fwd;
      hz.FwdSelB    = rt_fwd;
    end
  end

`ifdef BRANCH_HAZARD_STATS_EN
  logic [STAT_W-1:0] branch_cnt;
  logic [STAT_W-1:0] taken_cnt;
  logic [STAT_W-1:0] stall_cyc;

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
      stall_cyc  <= '0;
    end else begin
      if (!stall && rs_active) branch_cnt <= branch_cnt + 1'b1;
      if (flush)               taken_cnt  <= taken_cnt + 1'b1;
      if (stall)               stall_cyc  <= stall_cyc + 1'b1;
    end
  end

  assign hz.BranchCount = reset ? '0 : branch_cnt;
  assign hz.TakenCount  = reset ? '0 : taken_cnt;
  assign hz.StallCycles = reset ? '0 : stall_cyc;
`else
  assign hz.BranchCount = {STAT_W{1'b0}};
  assign hz.TakenCount  = {STAT_W{1'b0}};
  assign hz.StallCycles = {STAT_W{1'b0}};
`endif

endmodule
